dphy_rx_byte_aligner: RTL and testbench
=======================================

Name: dphy_rx_byte_aligner

Overview:
Sits in the sys_clk domain directly after the D-PHY input deserialiser, which delivers bit-correct but byte-unaligned 8-bit words, LSB first. The block sequences HS reception for one data lane:
- waits for the lane to enter HS-receive;
- searches the bitstream for the SoT sync byte and locks the bit offset;
- emits aligned payload bytes until the packet layer signals end of packet.

Parameters:
SYNC_BYTE, 8'hB8, SoT sync pattern as a byte (LSB-first on the wire).
CHECK_ZERO_LEADER, 1, if 1 the window bits below the match offset must all be 0 (HS-zero) for a match.
TIMEOUT_CYCLES, 255, SEARCH cycles before err_sync_timeout pulses; 0 disables the timeout; maximum 65535.

Ports:
sys_clk  in  1  system byte clock; all logic is on its rising edge.
sys_rst_n  in  1  reset, synchronous, active-low.
din  in  8  unaligned deserialised word; bits in later-received order occupy higher bit positions.
wait_for_sync  in  1  high while the lane is in HS-receive and alignment is wanted; low forces IDLE.
packet_done  in  1  one-cycle pulse from the packet layer at end of packet.
dout  out  8  aligned byte.
dout_vld  out  1  dout holds a payload byte.
sync_found  out  1  one-cycle pulse when sync is detected.
locked  out  1  high while in LOCKED.
align_offset  out  3  locked bit offset k (debug).
err_sync_timeout  out  1  one-cycle pulse on search timeout.

Behaviour:
- Reset: while sys_rst_n=0 at an edge, all of the following are cleared: state=IDLE, prev_word=0, offset=0, timeout count=0, dout=0, dout_vld=0, sync_found=0, locked=0, align_offset=0, err_sync_timeout=0. Reset mid-packet drops lock; no further bytes are output.
- prev_word <= din on every non-reset edge. window[15:0] = {din, prev_word} (combinational).
- Match at offset k (0..7): window[k+7:k]==SYNC_BYTE. If CHECK_ZERO_LEADER=1 and k>0, window[k-1:0] must also be 0. When several offsets match, the lowest k wins.
- States: IDLE, SEARCH, LOCKED. Priority at each edge: reset > wait_for_sync=0 > the rules below.
- IDLE: if wait_for_sync=1, go to SEARCH and clear the timeout count.
- SEARCH:
  - On a match: go to LOCKED, offset<=k, sync_found<=1 for one cycle, clear the timeout count.
  - Otherwise the count increments. If TIMEOUT_CYCLES!=0 and count==TIMEOUT_CYCLES-1: err_sync_timeout<=1 for one cycle, count<=0, stay in SEARCH.
  - packet_done is ignored in SEARCH.
- LOCKED:
  - Each edge: dout<=window[offset+7:offset], dout_vld<=1.
  - On packet_done=1 (checked before the byte update): go to IDLE, dout_vld<=0, dout holds its last value. No further sync search happens until IDLE re-enters SEARCH, which takes at least one cycle.
- wait_for_sync=0 in any state: go to IDLE, dout_vld<=0, locked<=0. If this coincides with a match, no sync_found is generated.
- Latency: if the sync match occurs at edge E, sync_found and locked are high after E. The first payload byte (the bits following the sync) appears on dout with dout_vld=1 after edge E+1. Output is one byte per cycle thereafter, with no gaps.
- locked = (state==LOCKED), registered. align_offset = offset.
- The sync byte itself is never output.

Test Plan:
1. Offset 0: wait_for_sync=1, din = 00,00,B8,11,22, then packet_done pulse.
   -> sync_found pulses the cycle after B8, align_offset=0.
   -> dout=11 then 22 with dout_vld=1.
   -> dout_vld=0 the cycle after packet_done; state returns to IDLE then SEARCH.
2. Offset 3: din = 00,C0,8D,10.
   -> match on {8D,C0}, align_offset=3.
   -> next cycle dout=0x11, dout_vld=1.
3. Leader check: din = 00,C3,8D (CHECK_ZERO_LEADER=1).
   -> no sync_found (nonzero leader bits).
   -> with CHECK_ZERO_LEADER=0, the same stimulus gives sync_found at offset 3.
4. Timeout: TIMEOUT_CYCLES=8, wait_for_sync=1, din=00 constantly.
   -> err_sync_timeout pulses every 8 cycles in SEARCH; sync_found never asserts.
5. Abort: while LOCKED, drop wait_for_sync for one cycle.
   -> locked=0 and dout_vld=0 next cycle.
   -> reassert wait_for_sync with a B8 stream -> relock with a fresh sync_found.
6. Reset mid-packet: assert sys_rst_n=0 while LOCKED with dout_vld=1.
   -> next edge all outputs are 0 and state is IDLE.
   -> releasing reset with wait_for_sync=1 enters SEARCH one cycle later.

Source files
------------

// File: rtl/dphy_rx_byte_aligner.sv
// D-PHY HS receive byte aligner for one data lane: waits for HS-receive, locks the
// bit offset on the SoT sync byte, then emits aligned payload bytes until end of packet.
module dphy_rx_byte_aligner #(
  parameter logic [7:0]  SYNC_BYTE         = 8'hB8,
  parameter bit          CHECK_ZERO_LEADER = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES    = 32'd255
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] din,
  input  logic       wait_for_sync,
  input  logic       packet_done,
  output logic [7:0] dout,
  output logic       dout_vld,
  output logic       sync_found,
  output logic       locked,
  output logic [2:0] align_offset,
  output logic       err_sync_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 32'd0);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

  state_t      state_r, state_s;
  logic [7:0]  prev_word_r;
  logic [2:0]  offset_r, offset_s;
  logic [15:0] tcount_r, tcount_s;
  logic [7:0]  dout_r, dout_s;
  logic        dout_vld_r, dout_vld_s;
  logic        sync_found_r, sync_found_s;
  logic        locked_r;
  logic        err_r, err_s;

  logic [15:0] window_s;
  logic [15:0] shifted_s;
  logic [7:0]  aligned_s;
  logic        match_s;
  logic [2:0]  match_k_s;

  // Sync byte sits at bit k of the window; optionally all earlier bits must be HS-zero.
  function automatic logic offset_hit(input logic [15:0] w, input int k);
    logic [15:0] sh;
    logic [15:0] lead_mask;
    sh        = w >> k;
    lead_mask = (16'd1 << k) - 16'd1;
    offset_hit = (sh[7:0] == SYNC_BYTE) &&
                 (!CHECK_ZERO_LEADER || ((w & lead_mask) == 16'd0));
  endfunction

  assign window_s  = {din, prev_word_r};
  assign shifted_s = window_s >> offset_r;
  assign aligned_s = shifted_s[7:0];

  // Scan offsets from high to low so the lowest matching offset is the one kept.
  always_comb begin
    match_s   = 1'b0;
    match_k_s = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      match_k_s = offset_hit(window_s, k) ? 3'(k) : match_k_s;
      match_s   = match_s | offset_hit(window_s, k);
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s      = state_r;
    offset_s     = offset_r;
    tcount_s     = tcount_r;
    dout_s       = dout_r;
    dout_vld_s   = 1'b0;
    sync_found_s = 1'b0;
    err_s        = 1'b0;
    if (!wait_for_sync) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_s  = ST_SEARCH;
          tcount_s = 16'd0;
        end
        ST_SEARCH: begin
          if (match_s) begin
            state_s      = ST_LOCKED;
            offset_s     = match_k_s;
            sync_found_s = 1'b1;
            tcount_s     = 16'd0;
          end else if (TMO_EN && (tcount_r == TMO_LAST)) begin
            err_s    = 1'b1;
            tcount_s = 16'd0;
          end else begin
            tcount_s = tcount_r + 16'd1;
          end
        end
        ST_LOCKED: begin
          // End of packet wins over the byte update; dout keeps its last byte.
          if (packet_done) begin
            state_s = ST_IDLE;
          end else begin
            dout_s     = aligned_s;
            dout_vld_s = 1'b1;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_r      <= ST_IDLE;
      prev_word_r  <= 8'd0;
      offset_r     <= 3'd0;
      tcount_r     <= 16'd0;
      dout_r       <= 8'd0;
      dout_vld_r   <= 1'b0;
      sync_found_r <= 1'b0;
      locked_r     <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_s;
      prev_word_r  <= din;
      offset_r     <= offset_s;
      tcount_r     <= tcount_s;
      dout_r       <= dout_s;
      dout_vld_r   <= dout_vld_s;
      sync_found_r <= sync_found_s;
      locked_r     <= (state_s == ST_LOCKED);
      err_r        <= err_s;
    end
  end

  assign dout             = dout_r;
  assign dout_vld         = dout_vld_r;
  assign sync_found       = sync_found_r;
  assign locked           = locked_r;
  assign align_offset     = offset_r;
  assign err_sync_timeout = err_r;

endmodule

// File: tb/tb_dphy_rx_byte_aligner.sv
// Scoreboard bench for dphy_rx_byte_aligner: expected payload bytes and sync offsets are
// queued as stimulus is driven and popped whenever the default-parameter DUT produces them.
module tb_dphy_rx_byte_aligner;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic [7:0] din;
  logic       wait_for_sync;
  logic       packet_done;

  logic [7:0] dout, nz_dout, tm_dout;
  logic       dout_vld, nz_dout_vld, tm_dout_vld;
  logic       sync_found, nz_sync_found, tm_sync_found;
  logic       locked, nz_locked, tm_locked;
  logic [2:0] align_offset, nz_align_offset, tm_align_offset;
  logic       err_sync_timeout, nz_err, tm_err;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_bytes[$];
  logic [2:0] exp_syncs[$];
  logic       tm_sync_seen;

  always #5 sys_clk = ~sys_clk;

  dphy_rx_byte_aligner u_dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .din(din),
    .wait_for_sync(wait_for_sync), .packet_done(packet_done),
    .dout(dout), .dout_vld(dout_vld), .sync_found(sync_found), .locked(locked),
    .align_offset(align_offset), .err_sync_timeout(err_sync_timeout)
  );

  dphy_rx_byte_aligner #(.CHECK_ZERO_LEADER(1'b0)) u_nz (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .din(din),
    .wait_for_sync(wait_for_sync), .packet_done(packet_done),
    .dout(nz_dout), .dout_vld(nz_dout_vld), .sync_found(nz_sync_found), .locked(nz_locked),
    .align_offset(nz_align_offset), .err_sync_timeout(nz_err)
  );

  dphy_rx_byte_aligner #(.TIMEOUT_CYCLES(32'd8)) u_tmo (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .din(din),
    .wait_for_sync(wait_for_sync), .packet_done(packet_done),
    .dout(tm_dout), .dout_vld(tm_dout_vld), .sync_found(tm_sync_found), .locked(tm_locked),
    .align_offset(tm_align_offset), .err_sync_timeout(tm_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic [7:0] d);
    din = d;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_dout"},   32'(dout), 32'h0);
    check_eq({tag, "_vld"},    32'(dout_vld), 32'h0);
    check_eq({tag, "_sync"},   32'(sync_found), 32'h0);
    check_eq({tag, "_locked"}, 32'(locked), 32'h0);
    check_eq({tag, "_offset"}, 32'(align_offset), 32'h0);
    check_eq({tag, "_err"},    32'(err_sync_timeout), 32'h0);
  endtask

  // Every valid byte and every sync pulse must match the next queued expectation.
  always @(negedge sys_clk) begin
    if (dout_vld === 1'b1) begin
      if (exp_bytes.size() == 0) check_eq("dout_unexpected", 32'(dout), 32'hFFFF_FFFF);
      else check_eq("dout", 32'(dout), 32'(exp_bytes.pop_front()));
    end
    if (sync_found === 1'b1) begin
      if (exp_syncs.size() == 0) check_eq("sync_unexpected", 32'(align_offset), 32'hFFFF_FFFF);
      else check_eq("sync_offset", 32'(align_offset), 32'(exp_syncs.pop_front()));
    end
  end

  initial begin
    sys_rst_n = 1'b0; wait_for_sync = 1'b0; packet_done = 1'b0; din = 8'h00;
    tm_sync_seen = 1'b0;
    cycle(8'h00);
    cycle(8'h00);
    check_all_zero("reset");
    sys_rst_n = 1'b1;
    wait_for_sync = 1'b1;

    // Offset 0 packet
    cycle(8'h00);
    cycle(8'h00);
    cycle(8'hB8);
    exp_syncs.push_back(3'd0);
    cycle(8'h11);
    check_eq("t1_sync", 32'(sync_found), 32'h1);
    check_eq("t1_locked", 32'(locked), 32'h1);
    check_eq("t1_offset", 32'(align_offset), 32'h0);
    check_eq("t1_vld_first", 32'(dout_vld), 32'h0);
    exp_bytes.push_back(8'h11);
    exp_bytes.push_back(8'h22);
    cycle(8'h22);
    cycle(8'h33);
    packet_done = 1'b1;
    cycle(8'h44);
    packet_done = 1'b0;
    check_eq("t1_vld_done", 32'(dout_vld), 32'h0);
    check_eq("t1_locked_done", 32'(locked), 32'h0);
    check_eq("t1_dout_hold", 32'(dout), 32'h22);
    cycle(8'h00);

    // Offset 3 packet
    cycle(8'h00);
    cycle(8'hC0);
    exp_syncs.push_back(3'd3);
    cycle(8'h8D);
    check_eq("t2_locked", 32'(locked), 32'h1);
    check_eq("t2_offset", 32'(align_offset), 32'h3);
    exp_bytes.push_back(8'h11);
    cycle(8'h10);
    check_eq("t2_dout", 32'(dout), 32'h11);
    check_eq("t2_vld", 32'(dout_vld), 32'h1);
    packet_done = 1'b1;
    cycle(8'h00);
    packet_done = 1'b0;
    check_eq("t2_vld_done", 32'(dout_vld), 32'h0);

    // Leader check: nonzero bits below the sync only block the checking instance
    cycle(8'h00);
    cycle(8'h00);
    cycle(8'hC3);
    cycle(8'h8D);
    check_eq("t3_no_sync", 32'(sync_found), 32'h0);
    check_eq("t3_nz_sync", 32'(nz_sync_found), 32'h1);
    check_eq("t3_nz_offset", 32'(nz_align_offset), 32'h3);
    cycle(8'h00);
    check_eq("t3_not_locked", 32'(locked), 32'h0);

    // Timeout every 8 SEARCH cycles on the short-timeout instance
    wait_for_sync = 1'b0;
    cycle(8'h00);
    wait_for_sync = 1'b1;
    cycle(8'h00);
    for (int i = 1; i <= 24; i++) begin
      cycle(8'h00);
      check_eq($sformatf("t4_err_%0d", i), 32'(tm_err), 32'((i % 8) == 0));
      tm_sync_seen = tm_sync_seen | tm_sync_found;
    end
    check_eq("t4_no_sync", 32'(tm_sync_seen), 32'h0);
    check_eq("t4_dut_no_err", 32'(err_sync_timeout), 32'h0);

    // Abort by dropping wait_for_sync, then relock
    cycle(8'hB8);
    exp_syncs.push_back(3'd0);
    cycle(8'hAA);
    exp_bytes.push_back(8'hAA);
    cycle(8'h55);
    wait_for_sync = 1'b0;
    cycle(8'h66);
    check_eq("t5_locked_abort", 32'(locked), 32'h0);
    check_eq("t5_vld_abort", 32'(dout_vld), 32'h0);
    wait_for_sync = 1'b1;
    cycle(8'h00);
    cycle(8'hB8);
    exp_syncs.push_back(3'd0);
    cycle(8'h5A);
    check_eq("t5_resync", 32'(sync_found), 32'h1);
    exp_bytes.push_back(8'h5A);
    exp_bytes.push_back(8'hC3);
    cycle(8'hC3);
    cycle(8'h00);
    check_eq("t5_locked", 32'(locked), 32'h1);
    check_eq("t5_vld", 32'(dout_vld), 32'h1);

    // Reset mid-packet, then SEARCH must be entered on the first edge after release
    sys_rst_n = 1'b0;
    cycle(8'h00);
    check_all_zero("t6_reset");
    sys_rst_n = 1'b1;
    cycle(8'hB8);
    exp_syncs.push_back(3'd0);
    cycle(8'h77);
    check_eq("t6_sync", 32'(sync_found), 32'h1);
    wait_for_sync = 1'b0;
    cycle(8'h00);
    check_eq("t6_vld_off", 32'(dout_vld), 32'h0);
    check_eq("t6_locked_off", 32'(locked), 32'h0);

    cycle(8'h00);
    check_eq("bytes_left", 32'(exp_bytes.size()), 32'h0);
    check_eq("syncs_left", 32'(exp_syncs.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
